// File: rtl/mul_bus_master.sv
// Bus initiator for the multiplier slave: writes the operands, starts the slave, waits for done
// (by polling or interrupt), reads the 64-bit result, clears the slave and returns the product.
module mul_bus_master #(
    parameter int         USE_INTR   = 0,
    parameter int         READ_LAT   = 1,
    parameter int         TIMEOUT    = 1023,
    parameter logic [7:0] ADDR_A     = 8'h0,
    parameter logic [7:0] ADDR_B     = 8'h1,
    parameter logic [7:0] ADDR_RH    = 8'h2,
    parameter logic [7:0] ADDR_RL    = 8'h3,
    parameter logic [7:0] ADDR_START = 8'h4,
    parameter logic [7:0] ADDR_CLR   = 8'h5,
    parameter logic [7:0] ADDR_DONE  = 8'h6,
    parameter logic [7:0] ADDR_IEN   = 8'h7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_result,
    output logic        rsp_err,
    output logic        M_sel,
    output logic        M_wr,
    output logic [7:0]  M_address,
    output logic [31:0] M_dout,
    input  logic [31:0] M_din,
    input  logic        m_interrupt
);

    // Handshakes: a request transfers on a clock where req_valid && req_ready; a response
    // transfers on a clock where rsp_valid && rsp_ready. rsp_valid/rsp_result/rsp_err hold until then.

    localparam int              CW        = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   WAIT_LAST = CW'(TIMEOUT - 1);
    localparam logic [1:0]      LAT_LAST  = 2'(READ_LAT);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_WR_A     = 4'd1;
    localparam logic [3:0] S_WR_B     = 4'd2;
    localparam logic [3:0] S_WR_IEN   = 4'd3;
    localparam logic [3:0] S_WR_START = 4'd4;
    localparam logic [3:0] S_WAIT     = 4'd5;
    localparam logic [3:0] S_RD_H     = 4'd6;
    localparam logic [3:0] S_RD_L     = 4'd7;
    localparam logic [3:0] S_WR_CLR   = 4'd8;
    localparam logic [3:0] S_RESP     = 4'd9;

    logic [3:0]    state;
    logic [3:0]    next_state;
    logic [1:0]    lat_cnt;
    logic [CW-1:0] wait_cnt;
    logic [31:0]   b_q;
    logic          rd_last;
    logic          done;
    logic          timed_out;
    logic          bus_sel;
    logic          bus_wr;
    logic [7:0]    bus_addr;
    logic [31:0]   bus_data;

    always_comb begin
        rd_last   = (lat_cnt == LAT_LAST);
        timed_out = (wait_cnt == WAIT_LAST);
        if (USE_INTR != 0) begin
            done = m_interrupt;
        end else begin
            done = rd_last && (M_din[1:0] == 2'b11);
        end
        next_state = state;
        case (state)
            S_IDLE:     if (req_valid && req_ready) next_state = S_WR_A;
            S_WR_A:     next_state = S_WR_B;
            S_WR_B:     next_state = (USE_INTR != 0) ? S_WR_IEN : S_WR_START;
            S_WR_IEN:   next_state = S_WR_START;
            S_WR_START: next_state = S_WAIT;
            // done is checked first so a done on the last allowed clock still reads the result
            S_WAIT: begin
                if (done) begin
                    next_state = S_RD_H;
                end else if (timed_out) begin
                    next_state = S_WR_CLR;
                end
            end
            S_RD_H:     if (rd_last) next_state = S_RD_L;
            S_RD_L:     if (rd_last) next_state = S_WR_CLR;
            S_WR_CLR:   next_state = S_RESP;
            S_RESP:     if (rsp_ready) next_state = S_IDLE;
            default:    next_state = S_IDLE;
        endcase
    end

    // Bus signals are registered from the state being entered, so they line up with it.
    always_comb begin
        bus_sel  = 1'b0;
        bus_wr   = 1'b0;
        bus_addr = 8'h0;
        bus_data = 32'h0;
        case (next_state)
            S_WR_A:     begin bus_sel = 1'b1; bus_wr = 1'b1; bus_addr = ADDR_A;     bus_data = req_a; end
            S_WR_B:     begin bus_sel = 1'b1; bus_wr = 1'b1; bus_addr = ADDR_B;     bus_data = b_q;   end
            S_WR_IEN:   begin bus_sel = 1'b1; bus_wr = 1'b1; bus_addr = ADDR_IEN;   bus_data = 32'd1; end
            S_WR_START: begin bus_sel = 1'b1; bus_wr = 1'b1; bus_addr = ADDR_START; bus_data = 32'd1; end
            S_WR_CLR:   begin bus_sel = 1'b1; bus_wr = 1'b1; bus_addr = ADDR_CLR;   bus_data = 32'd1; end
            S_WAIT: begin
                if (USE_INTR == 0) begin
                    bus_sel  = 1'b1;
                    bus_addr = ADDR_DONE;
                end
            end
            S_RD_H:     begin bus_sel = 1'b1; bus_addr = ADDR_RH; end
            S_RD_L:     begin bus_sel = 1'b1; bus_addr = ADDR_RL; end
            default:    ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            M_sel      <= 1'b0;
            M_wr       <= 1'b0;
            M_address  <= 8'h0;
            M_dout     <= 32'h0;
            req_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_result <= 64'h0;
            rsp_err    <= 1'b0;
            wait_cnt   <= '0;
            lat_cnt    <= 2'd0;
            b_q        <= 32'h0;
        end else begin
            state     <= next_state;
            M_sel     <= bus_sel;
            M_wr      <= bus_wr;
            M_address <= bus_addr;
            M_dout    <= bus_data;
            req_ready <= (next_state == S_IDLE);
            rsp_valid <= (next_state == S_RESP);
            // lat_cnt restarts on every new bus op, including back-to-back done polls
            if (next_state != state || rd_last) begin
                lat_cnt <= 2'd0;
            end else begin
                lat_cnt <= lat_cnt + 2'd1;
            end
            wait_cnt <= (state == S_WAIT) ? wait_cnt + CW'(1) : '0;
            if (state == S_IDLE && next_state == S_WR_A) begin
                b_q     <= req_b;
                rsp_err <= 1'b0;
            end
            if (state == S_WAIT && next_state == S_WR_CLR) begin
                rsp_err    <= 1'b1;
                rsp_result <= 64'h0;
            end
            if (state == S_RD_H && rd_last) rsp_result[63:32] <= M_din;
            if (state == S_RD_L && rd_last) rsp_result[31:0]  <= M_din;
        end
    end

endmodule

// File: tb/tb_mul_bus_master.sv
// Bench for mul_bus_master: three configurations (poll/default, interrupt, poll with READ_LAT=2)
// each talking to a behavioural multiplier slave; table vectors, a reset sequence and random traffic.
module tb_mul_bus_master;

    localparam int N = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        req_valid [N];
    logic        req_ready [N];
    logic [31:0] req_a [N];
    logic [31:0] req_b [N];
    logic        rsp_valid [N];
    logic        rsp_ready [N];
    logic [63:0] rsp_result [N];
    logic        rsp_err [N];
    logic        m_sel [N];
    logic        m_wr [N];
    logic [7:0]  m_address [N];
    logic [31:0] m_dout [N];

    logic [31:0] s_a [N];
    logic [31:0] s_b [N];
    logic [63:0] s_prod [N];
    logic [31:0] pipe1 [N];
    logic [31:0] pipe2 [N];
    logic        s_busy [N];
    logic        s_done [N];
    logic        s_ien [N];
    int          s_cnt [N];
    int          s_delay [N];
    bit          s_hang [N];

    logic [41:0] wr_obs[$];
    logic [41:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    for (genvar i = 0; i < N; i++) begin : g_dut
        mul_bus_master #(
            .USE_INTR (i == 1 ? 1 : 0),
            .READ_LAT (i == 2 ? 2 : 1),
            .TIMEOUT  (i == 0 ? 1023 : 15)
        ) u_dut (
            .clk         (clk),
            .reset       (reset),
            .req_valid   (req_valid[i]),
            .req_ready   (req_ready[i]),
            .req_a       (req_a[i]),
            .req_b       (req_b[i]),
            .rsp_valid   (rsp_valid[i]),
            .rsp_ready   (rsp_ready[i]),
            .rsp_result  (rsp_result[i]),
            .rsp_err     (rsp_err[i]),
            .M_sel       (m_sel[i]),
            .M_wr        (m_wr[i]),
            .M_address   (m_address[i]),
            .M_dout      (m_dout[i]),
            .M_din       (i == 2 ? pipe2[i] : pipe1[i]),
            .m_interrupt (s_ien[i] & s_done[i])
        );
    end

    // Slave model: registers, a done countdown after START, and read data delayed by READ_LAT.
    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            logic [31:0] rd;
            case (m_address[k])
                8'h2:    rd = s_prod[k][63:32];
                8'h3:    rd = s_prod[k][31:0];
                8'h6:    rd = {30'd0, s_done[k] ? 2'b11 : (s_busy[k] ? 2'b01 : 2'b10)};
                default: rd = 32'd0;
            endcase
            pipe1[k] <= (m_sel[k] && !m_wr[k]) ? rd : 32'hDEADBEEF;
            pipe2[k] <= pipe1[k];
            if (m_sel[k] === 1'b1 && m_wr[k] === 1'b1) wr_obs.push_back({2'(k), m_address[k], m_dout[k]});
            if (reset) begin
                s_busy[k] <= 1'b0;
                s_done[k] <= 1'b0;
                s_ien[k]  <= 1'b0;
                s_prod[k] <= 64'd0;
                s_cnt[k]  <= 0;
            end else begin
                if (s_busy[k] && !s_hang[k]) begin
                    if (s_cnt[k] == 0) begin
                        s_done[k] <= 1'b1;
                        s_busy[k] <= 1'b0;
                        s_prod[k] <= {32'd0, s_a[k]} * {32'd0, s_b[k]};
                    end else begin
                        s_cnt[k] <= s_cnt[k] - 1;
                    end
                end
                if (m_sel[k] === 1'b1 && m_wr[k] === 1'b1) begin
                    case (m_address[k])
                        8'h0: s_a[k] <= m_dout[k];
                        8'h1: s_b[k] <= m_dout[k];
                        8'h4: begin
                            s_busy[k] <= 1'b1;
                            s_cnt[k]  <= s_delay[k];
                            s_done[k] <= 1'b0;
                            s_prod[k] <= 64'd0;
                        end
                        8'h5: begin
                            s_done[k] <= 1'b0;
                            s_busy[k] <= 1'b0;
                        end
                        8'h7: s_ien[k] <= m_dout[k][0];
                        default: ;
                    endcase
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input int k);
        check("rst_sel", m_sel[k], 0);
        check("rst_wr", m_wr[k], 0);
        check("rst_addr", m_address[k], 0);
        check("rst_dout", m_dout[k], 0);
        check("rst_req_ready", req_ready[k], 0);
        check("rst_rsp_valid", rsp_valid[k], 0);
        check("rst_rsp_result", rsp_result[k], 0);
        check("rst_rsp_err", rsp_err[k], 0);
    endtask

    // Reference: the product is plain 64-bit arithmetic; a slave that never finishes yields error.
    function automatic logic [64:0] model(input logic [31:0] a, input logic [31:0] b, input bit hang);
        if (hang) return {1'b1, 64'd0};
        return {1'b0, {32'd0, a} * {32'd0, b}};
    endfunction

    task automatic accept(input int k, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        while (req_ready[k] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_idle", req_ready[k], 1);
        req_valid[k] = 1'b1;
        req_a[k] = a;
        req_b[k] = b;
        @(negedge clk);
        req_valid[k] = 1'b0;
        req_a[k] = $urandom;
        req_b[k] = $urandom;
        check("req_ready_busy", req_ready[k], 0);
    endtask

    task automatic run_txn(input int k, input logic [31:0] a, input logic [31:0] b, input int delay,
                           input bit hang, input int hold, input logic [63:0] exp_res, input bit exp_err);
        int n;
        int base;
        s_delay[k] = delay;
        s_hang[k] = hang;
        base = wr_obs.size();
        accept(k, a, b);
        n = 0;
        while (rsp_valid[k] !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("rsp_valid_arrives", rsp_valid[k], 1);
        check("rsp_result", rsp_result[k], exp_res);
        check("rsp_err", rsp_err[k], exp_err);
        for (int h = 0; h < hold; h++) begin
            req_valid[k] = 1'b1;
            @(negedge clk);
            check("hold_rsp_valid", rsp_valid[k], 1);
            check("hold_result", rsp_result[k], exp_res);
            check("hold_err", rsp_err[k], exp_err);
            check("hold_req_ready", req_ready[k], 0);
        end
        req_valid[k] = 1'b0;
        rsp_ready[k] = 1'b1;
        @(negedge clk);
        rsp_ready[k] = 1'b0;
        check("rsp_valid_drop", rsp_valid[k], 0);
        check("req_ready_back", req_ready[k], 1);
        repeat (3) @(negedge clk);
        check("bus_quiet", m_sel[k], 0);
        exp_q.delete();
        exp_q.push_back({2'(k), 8'h0, a});
        exp_q.push_back({2'(k), 8'h1, b});
        if (k == 1) exp_q.push_back({2'(k), 8'h7, 32'd1});
        exp_q.push_back({2'(k), 8'h4, 32'd1});
        exp_q.push_back({2'(k), 8'h5, 32'd1});
        check("wr_count", 64'(wr_obs.size() - base), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && base + i < wr_obs.size(); i++) begin
            check("wr_seq", wr_obs[base + i], exp_q[i]);
        end
    endtask

    typedef struct {
        int          inst;
        logic [31:0] a;
        logic [31:0] b;
        int          delay;
        bit          hang;
        int          hold;
        logic [63:0] res;
        bit          err;
    } vec_t;

    vec_t vecs [9];

    initial begin
        logic [64:0] m;
        int base;
        vecs[0] = '{0, 32'h10,       32'h22222222, 3, 1'b0, 0,  64'h0000000222222220, 1'b0};
        vecs[1] = '{1, 32'h40,       32'h50,       2, 1'b0, 1,  64'h0000000000001400, 1'b0};
        vecs[2] = '{2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1'b0, 2,  64'hFFFFFFFE00000001, 1'b0};
        vecs[3] = '{2, 32'h1234,     32'h5678,     0, 1'b1, 0,  64'h0,                1'b1};
        vecs[4] = '{1, 32'h99,       32'h77,       0, 1'b1, 1,  64'h0,                1'b1};
        vecs[5] = '{0, 32'h3,        32'h80000000, 2, 1'b0, 20, 64'h0000000180000000, 1'b0};
        vecs[6] = '{0, 32'hFFFFFFFF, 32'h2,        0, 1'b0, 0,  64'h00000001FFFFFFFE, 1'b0};
        vecs[7] = '{1, 32'h80000000, 32'h80000000, 4, 1'b0, 0,  64'h4000000000000000, 1'b0};
        vecs[8] = '{0, 32'h5,        32'h6,        0, 1'b1, 0,  64'h0,                1'b1};

        for (int k = 0; k < N; k++) begin
            req_valid[k] = 1'b0;
            req_a[k] = 32'd0;
            req_b[k] = 32'd0;
            rsp_ready[k] = 1'b0;
            s_delay[k] = 0;
            s_hang[k] = 1'b0;
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < N; k++) check_reset_outputs(k);
        reset = 1'b0;
        @(negedge clk);
        for (int k = 0; k < N; k++) check("req_ready_after_reset", req_ready[k], 1);

        for (int v = 0; v < 9; v++) begin
            run_txn(vecs[v].inst, vecs[v].a, vecs[v].b, vecs[v].delay, vecs[v].hang,
                    vecs[v].hold, vecs[v].res, vecs[v].err);
        end

        // Reset while polling for done: abort at once, no clear write, then a normal transaction.
        s_hang[0] = 1'b1;
        base = wr_obs.size();
        accept(0, 32'hABCD, 32'h1111);
        repeat (10) @(negedge clk);
        check("wait_poll_sel", m_sel[0], 1);
        check("wait_poll_addr", m_address[0], 8'h6);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs(0);
        reset = 1'b0;
        @(negedge clk);
        check("req_ready_after_mid_reset", req_ready[0], 1);
        repeat (3) @(negedge clk);
        check("no_clr_on_reset", 64'(wr_obs.size() - base), 3);
        run_txn(0, 32'h7, 32'h9, 1, 1'b0, 0, 64'd63, 1'b0);

        for (int r = 0; r < 12; r++) begin
            int k;
            logic [31:0] a;
            logic [31:0] b;
            bit hang;
            k = $urandom_range(0, 2);
            a = ($urandom_range(0, 4) == 0) ? 32'hFFFFFFFF : $urandom;
            b = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            hang = (k != 0) && ($urandom_range(0, 5) == 0);
            m = model(a, b, hang);
            run_txn(k, a, b, $urandom_range(0, 4), hang, $urandom_range(0, 3), m[63:0], m[64]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
